// File: rtl/pps_mem_harness_if.sv
// rtl/pps_mem_harness_if.sv - im/dm bus between the pipelined processor and the memory harness
interface pps_mem_harness_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  im_rd;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [DATA_WIDTH-1:0] im_r_data;
  logic                  im_r_valid;
  logic                  dm_rd;
  logic                  dm_wr;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_w_data;
  logic [DATA_WIDTH-1:0] dm_r_data;
  logic                  dm_r_valid;

  modport master (
    output im_rd, im_addr, dm_rd, dm_wr, dm_addr, dm_w_data,
    input  im_r_data, im_r_valid, dm_r_data, dm_r_valid
  );

  modport slave (
    input  im_rd, im_addr, dm_rd, dm_wr, dm_addr, dm_w_data,
    output im_r_data, im_r_valid, dm_r_data, dm_r_valid
  );
endinterface

// File: rtl/pps_mem_harness.sv
// rtl/pps_mem_harness.sv - IM/DM memories with fixed-latency reads, preload port and post-run result checker
module pps_mem_harness #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int CHK_NUM    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         load_en,
  input  logic                         load_sel,
  input  logic [ADDR_WIDTH-1:0]        load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  pps_mem_harness_if.slave             bus,
  input  logic                         chk_wr,
  input  logic [$clog2(CHK_NUM)-1:0]   chk_idx,
  input  logic [ADDR_WIDTH-1:0]        chk_addr,
  input  logic [DATA_WIDTH-1:0]        chk_data,
  output logic                         oob,
  output logic                         chk_done,
  output logic                         chk_pass,
  output logic [$clog2(CHK_NUM+1)-1:0] err_cnt
);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CI_W   = $clog2(CHK_NUM);
  localparam int EC_W   = $clog2(CHK_NUM + 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] im_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] dm_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] tbl_addr [CHK_NUM];
  logic [DATA_WIDTH-1:0] tbl_data [CHK_NUM];
  logic [CHK_NUM-1:0]    tbl_vld;
  logic [CI_W-1:0]       ptr;

  logic                  run, in_idle, tbl_we;
  logic                  im_ok, dm_ok, ld_ok, chk_ok;
  logic                  im_req, dm_req, chk_miss;
  logic [DATA_WIDTH-1:0] im_word, dm_word, chk_word;
  logic [EC_W-1:0]       err_next;

  assign run     = (state == RUN);
  assign in_idle = (state == IDLE);
  assign tbl_we  = chk_wr && (state != CHECK);

  // Out-of-range addresses read as zero and never touch the arrays.
  assign im_ok  = 32'(bus.im_addr) < DEPTH;
  assign dm_ok  = 32'(bus.dm_addr) < DEPTH;
  assign ld_ok  = 32'(load_addr) < DEPTH;
  assign chk_ok = 32'(tbl_addr[ptr]) < DEPTH;

  assign im_word  = im_ok  ? im_mem[bus.im_addr[MEM_AW-1:0]] : '0;
  assign dm_word  = dm_ok  ? dm_mem[bus.dm_addr[MEM_AW-1:0]] : '0;
  assign chk_word = chk_ok ? dm_mem[tbl_addr[ptr][MEM_AW-1:0]] : '0;

  assign im_req   = run && bus.im_rd;
  assign dm_req   = run && bus.dm_rd;
  assign chk_miss = tbl_vld[ptr] && (chk_word != tbl_data[ptr]);
  assign err_next = err_cnt + EC_W'(chk_miss);

  // Arrays carry no reset so the program and data survive a reset.
  always_ff @(posedge clk) begin
    if (run && bus.dm_wr && dm_ok)
      dm_mem[bus.dm_addr[MEM_AW-1:0]] <= bus.dm_w_data;
    if (in_idle && load_en && ld_ok) begin
      if (load_sel)
        dm_mem[load_addr[MEM_AW-1:0]] <= load_data;
      else
        im_mem[load_addr[MEM_AW-1:0]] <= load_data;
    end
    if (tbl_we) begin
      tbl_addr[chk_idx] <= chk_addr;
      tbl_data[chk_idx] <= chk_data;
    end
  end

  // Stage 0 captures the word at the request edge, which makes same-edge writes read-first.
  logic [RD_LAT-1:0]     im_vp, dm_vp;
  logic [DATA_WIDTH-1:0] im_dp [RD_LAT];
  logic [DATA_WIDTH-1:0] dm_dp [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_vp          <= '0;
      dm_vp          <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        im_dp[i] <= '0;
        dm_dp[i] <= '0;
      end
      bus.im_r_valid <= 1'b0;
      bus.im_r_data  <= '0;
      bus.dm_r_valid <= 1'b0;
      bus.dm_r_data  <= '0;
    end else begin
      im_vp[0] <= im_req;
      im_dp[0] <= im_word;
      dm_vp[0] <= dm_req;
      dm_dp[0] <= dm_word;
      for (int i = 1; i < RD_LAT; i++) begin
        im_vp[i] <= im_vp[i-1];
        im_dp[i] <= im_dp[i-1];
        dm_vp[i] <= dm_vp[i-1];
        dm_dp[i] <= dm_dp[i-1];
      end
      bus.im_r_valid <= im_vp[RD_LAT-1];
      bus.dm_r_valid <= dm_vp[RD_LAT-1];
      if (im_vp[RD_LAT-1])
        bus.im_r_data <= im_dp[RD_LAT-1];
      if (dm_vp[RD_LAT-1])
        bus.dm_r_data <= dm_dp[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      tbl_vld  <= '0;
      oob      <= 1'b0;
      chk_done <= 1'b0;
      chk_pass <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (tbl_we)
        tbl_vld[chk_idx] <= 1'b1;
      if ((run && ((bus.im_rd && !im_ok) || ((bus.dm_rd || bus.dm_wr) && !dm_ok))) ||
          (in_idle && load_en && !ld_ok))
        oob <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            err_cnt  <= '0;
            chk_done <= 1'b0;
            chk_pass <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= CHECK;
            ptr   <= '0;
          end
        end
        CHECK: begin
          err_cnt <= err_next;
          ptr     <= ptr + 1'b1;
          if (32'(ptr) == CHK_NUM - 1) begin
            state    <= DONE;
            chk_done <= 1'b1;
            chk_pass <= (err_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
